vga_timing_core: RTL and testbench

//  Single-clock VGA 640x480@60 timing engine with an integrated free-running clock divider.
//  - Divider count yields a pixel-rate enable (system clk / 2^DIV_LOG2; 100 MHz -> 25 MHz).
//  - Produces hs/vs, the active-pixel row/col address for the frame-data source, and

---
 rtl/vga_if.sv | 43 ++++
 rtl/vga_timing_core.sv | 121 ++++++++++++
 tb/tb_vga_timing_core.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_if.sv
// vga_if: pixel-source / connector side bundle
// of the VGA timing engine.
interface vga_if;
  logic [11:0] d_in;
  logic [31:0] clkdiv;
  logic        pix_tick;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;

  modport master (
    input  d_in,
    output clkdiv,
    output pix_tick,
    output row_addr,
    output col_addr,
    output rdn,
    output hs,
    output vs,
    output r,
    output g,
    output b
  );

  modport slave (
    output d_in,
    input  clkdiv,
    input  pix_tick,
    input  row_addr,
    input  col_addr,
    input  rdn,
    input  hs,
    input  vs,
    input  r,
    input  g,
    input  b
  );
endinterface

// File: rtl/vga_timing_core.sv
// vga_timing_core: 640x480@60 VGA timing engine
// with built-in pixel-rate divider and blanked RGB.
module vga_timing_core #(
  parameter int unsigned DIV_LOG2 = 2,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480
) (
  input logic   clk,
  input logic   clrn,
  vga_if.master vga
);
  localparam logic [9:0] H_LAST =
    10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST =
    10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W =
    10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W =
    10'(V_SYNC);
  // Visible columns start one tick early so that
  // col_addr is ready for the pixel source.
  localparam logic [9:0] H_VIS0 =
    10'(H_SYNC + H_BP - 1);
  localparam logic [9:0] H_VIS1 =
    10'(H_SYNC + H_BP + H_ACTIVE - 2);
  localparam logic [9:0] V_VIS0 =
    10'(V_SYNC + V_BP);
  localparam logic [9:0] V_VIS1 =
    10'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic [31:0] clkdiv;
  logic        pix_tick;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        h_end;
  logic        v_end;
  logic        vis;
  logic [9:0]  col_nxt;
  logic [8:0]  row_nxt;

  logic [8:0]  row_q;
  logic [9:0]  col_q;
  logic        rdn_q;
  logic        hs_q;
  logic        vs_q;
  logic [11:0] rgb_q;

  assign pix_tick = &clkdiv[DIV_LOG2-1:0];

  always_comb begin
    h_end   = (h_cnt == H_LAST);
    v_end   = (v_cnt == V_LAST);
    vis     = (h_cnt >= H_VIS0) &&
              (h_cnt <= H_VIS1) &&
              (v_cnt >= V_VIS0) &&
              (v_cnt <= V_VIS1);
    col_nxt = h_cnt - H_VIS0;
    row_nxt = 9'(v_cnt - V_VIS0);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clkdiv <= '0;
    end else begin
      clkdiv <= clkdiv + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_end) begin
        h_cnt <= '0;
        if (v_end) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      row_q <= '0;
      col_q <= '0;
      rdn_q <= 1'b1;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      rgb_q <= '0;
    end else if (pix_tick) begin
      row_q <= row_nxt;
      col_q <= col_nxt;
      rdn_q <= ~vis;
      hs_q  <= (h_cnt >= H_SYNC_W);
      vs_q  <= (v_cnt >= V_SYNC_W);
      rgb_q <= vis ? vga.d_in : 12'h000;
    end
  end

  assign vga.clkdiv   = clkdiv;
  assign vga.pix_tick = pix_tick;
  assign vga.row_addr = row_q;
  assign vga.col_addr = col_q;
  assign vga.rdn      = rdn_q;
  assign vga.hs       = hs_q;
  assign vga.vs       = vs_q;
  assign vga.r        = rgb_q[11:8];
  assign vga.g        = rgb_q[7:4];
  assign vga.b        = rgb_q[3:0];
endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: directed checks on a full-size
// instance and a shrunken-raster instance.
module tb_vga_timing_core;
  logic clk;
  logic clrn;
  int   checks;
  int   failures;
  int   ec;

  vga_if if_d ();
  vga_if if_s ();

  vga_timing_core u_d (
    .clk  (clk),
    .clrn (clrn),
    .vga  (if_d)
  );

  // 20x12 raster: sync 3/2, bp 2/3, active 10/4
  vga_timing_core #(
    .DIV_LOG2 (2),
    .H_TOTAL  (20),
    .H_SYNC   (3),
    .H_BP     (2),
    .H_ACTIVE (10),
    .V_TOTAL  (12),
    .V_SYNC   (2),
    .V_BP     (3),
    .V_ACTIVE (4)
  ) u_s (
    .clk  (clk),
    .clrn (clrn),
    .vga  (if_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) ec <= 0;
    else       ec <= ec + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int n);
    while (ec < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [11:0] rgb_s();
    return {if_s.r, if_s.g, if_s.b};
  endfunction

  function automatic logic [11:0] rgb_d();
    return {if_d.r, if_d.g, if_d.b};
  endfunction

  int s_vis;
  int s_red;
  int s_vslo;
  int s_hslo;
  int d_hslo;
  int d_hshi;

  initial begin
    checks   = 0;
    failures = 0;
    s_vis = 0; s_red = 0; s_vslo = 0;
    s_hslo = 0; d_hslo = 0; d_hshi = 0;
    if_d.d_in = 12'hFFF;
    if_s.d_in = 12'hF00;
    clrn = 1'b1;
    #1 clrn = 1'b0;
    #2;
    chk("rst_clkdiv", if_d.clkdiv, 0);
    chk("rst_rdn", {31'd0, if_d.rdn}, 1);
    chk("rst_hs", {31'd0, if_d.hs}, 0);
    chk("rst_vs", {31'd0, if_d.vs}, 0);
    chk("rst_rgb", {20'd0, rgb_d()}, 0);
    chk("rst_row", {23'd0, if_d.row_addr}, 0);
    chk("rst_col", {22'd0, if_d.col_addr}, 0);
    #9 clrn = 1'b1;

    wait_edge(2);
    chk("tick_c2", {31'd0, if_d.pix_tick}, 0);
    chk("div_c2", if_d.clkdiv, 2);
    wait_edge(3);
    chk("tick_c3", {31'd0, if_d.pix_tick}, 1);
    chk("hs_pre", {31'd0, if_d.hs}, 0);
    wait_edge(4);
    chk("div_c4", if_d.clkdiv, 4);
    chk("tick_c4", {31'd0, if_d.pix_tick}, 0);
    chk("d_row_v0", {23'd0, if_d.row_addr}, 477);
    chk("d_col_h0", {22'd0, if_d.col_addr}, 881);
    wait_edge(7);
    chk("tick_c7", {31'd0, if_d.pix_tick}, 1);

    for (int k = 0; k < 240; k++) begin
      wait_edge(4 * k + 4);
      if (!if_s.rdn) s_vis++;
      if (if_s.r == 4'hF) s_red++;
      if (!if_s.vs) s_vslo++;
      if (k < 20 && !if_s.hs) s_hslo++;
      if (k == 95)
        chk("d_hs_h95", {31'd0, if_d.hs}, 0);
      if (k == 96)
        chk("d_hs_h96", {31'd0, if_d.hs}, 1);
      if (k == 100) begin
        chk("d_blk_rdn", {31'd0, if_d.rdn}, 1);
        chk("d_blk_rgb", {20'd0, rgb_d()}, 0);
        chk("d_blk_col", {22'd0, if_d.col_addr},
            981);
      end
      if (k == 143)
        chk("d_col_h143", {22'd0, if_d.col_addr},
            0);
      if (k == 104) begin
        chk("s_first_col",
            {22'd0, if_s.col_addr}, 0);
        chk("s_first_row",
            {23'd0, if_s.row_addr}, 0);
        chk("s_first_rdn", {31'd0, if_s.rdn}, 0);
        chk("s_first_rgb", {20'd0, rgb_s()},
            32'hF00);
      end
    end
    chk("s_vis_ticks", s_vis, 40);
    chk("s_red_ticks", s_red, 40);
    chk("s_vs_low", s_vslo, 40);
    chk("s_hs_low", s_hslo, 3);

    if_s.d_in = 12'hFFF;
    wait_edge(963);
    chk("s_vs_f0_pre", {31'd0, if_s.vs}, 1);
    wait_edge(964);
    chk("s_vs_f0_fall", {31'd0, if_s.vs}, 0);
    wait_edge(1656);
    chk("s_last_col", {22'd0, if_s.col_addr}, 9);
    chk("s_last_row", {23'd0, if_s.row_addr}, 3);
    chk("s_last_rdn", {31'd0, if_s.rdn}, 0);
    chk("s_last_rgb", {20'd0, rgb_s()}, 32'hFFF);
    wait_edge(1657);
    if_s.d_in = 12'h000;
    wait_edge(1659);
    chk("s_hold_rgb", {20'd0, rgb_s()}, 32'hFFF);
    if_s.d_in = 12'hFFF;
    wait_edge(1660);
    chk("s_past_rdn", {31'd0, if_s.rdn}, 1);
    chk("s_past_rgb", {20'd0, rgb_s()}, 0);
    chk("s_past_col", {22'd0, if_s.col_addr}, 10);
    wait_edge(1923);
    chk("s_vs_f1_pre", {31'd0, if_s.vs}, 1);
    wait_edge(1924);
    chk("s_vs_f1_fall", {31'd0, if_s.vs}, 0);

    wait_edge(2432);
    chk("s_mid_col", {22'd0, if_s.col_addr}, 3);
    chk("s_mid_row", {23'd0, if_s.row_addr}, 1);
    chk("s_mid_rdn", {31'd0, if_s.rdn}, 0);
    #3 clrn = 1'b0;
    #1;
    chk("ar_rdn", {31'd0, if_s.rdn}, 1);
    chk("ar_rgb", {20'd0, rgb_s()}, 0);
    chk("ar_col", {22'd0, if_s.col_addr}, 0);
    chk("ar_row", {23'd0, if_s.row_addr}, 0);
    chk("ar_hs", {31'd0, if_s.hs}, 0);
    chk("ar_vs", {31'd0, if_s.vs}, 0);
    chk("ar_div", if_d.clkdiv, 0);
    #2 clrn = 1'b1;

    for (int k = 0; k < 800; k++) begin
      wait_edge(4 * k + 4);
      if (if_d.hs) d_hshi++;
      else         d_hslo++;
      if (k == 0) begin
        chk("re_col", {22'd0, if_s.col_addr},
            1020);
        chk("re_row", {23'd0, if_s.row_addr},
            507);
        chk("re_vs", {31'd0, if_s.vs}, 0);
      end
      if (k == 2)
        chk("re_hs_h2", {31'd0, if_s.hs}, 0);
      if (k == 3)
        chk("re_hs_h3", {31'd0, if_s.hs}, 1);
      if (k == 104) begin
        chk("re_first_col",
            {22'd0, if_s.col_addr}, 0);
        chk("re_first_row",
            {23'd0, if_s.row_addr}, 0);
        chk("re_first_rdn", {31'd0, if_s.rdn}, 0);
      end
    end
    chk("d_hs_low", d_hslo, 96);
    chk("d_hs_high", d_hshi, 704);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
